seg7_scan_display: RTL and testbench

- Parametrised successor to the team's 4-digit multiplexed 7-segment driver. Scans NUM_DIGITS common-anode digits and shows a binary value as decimal or hex.
- Decimal conversion is a sequential double-dabble engine with a load/busy handshake. The shown value changes only on commit, so no tearing.
- Adds leading-zero blanking, per-digit decimal points and an overflow indication. Sits between datapath counters/registers and the board display pins.

---
 rtl/seg7_scan_display.sv | 118 +++++++++++
 tb/tb_seg7_scan_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed common-anode 7-segment driver with a sequential
// double-dabble converter, hex mode, leading-zero blanking, DPs and overflow dashes.
module seg7_scan_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int INPUT_WIDTH   = 16,
    parameter int REFRESH_COUNT = 100_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] value,
    input  logic                   load,
    input  logic                   hex_mode,
    input  logic                   blank_lz,
    input  logic [NUM_DIGITS-1:0]  dp_mask,
    output logic [0:6]             seg,
    output logic                   dp,
    output logic [NUM_DIGITS-1:0]  digit,
    output logic                   busy
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(INPUT_WIDTH + 1);
    localparam int RW = $clog2(REFRESH_COUNT);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] DEC_MAX = 64'(10 ** NUM_DIGITS) - 64'd1;
    localparam logic [0:6] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                 r_state, w_next;
    logic [INPUT_WIDTH-1:0] r_val, r_sh;
    logic                   r_hex;
    logic [BW-1:0]          r_bcd, w_bcd_adj, r_disp;
    logic [CW-1:0]          r_cnt;
    logic                   r_ovf;
    logic [RW-1:0]          r_ref;
    logic [IW-1:0]          r_idx;
    logic [63:0]            w_ext;
    logic                   w_ovf;
    logic                   w_accept;
    logic                   w_wrap;
    logic [3:0]             w_nib;
    logic                   w_blank;

    assign busy     = r_state != IDLE;
    assign w_accept = r_state == IDLE && load;
    assign w_ext    = 64'(r_val);
    assign w_ovf    = r_hex ? (w_ext >> BW) != 64'd0 : w_ext > DEC_MAX;
    assign w_wrap   = r_ref == RW'(REFRESH_COUNT - 1);
    assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];
    // a digit is leading-zero when it and everything above it is zero
    assign w_blank  = blank_lz && r_idx != '0 && (r_disp >> {r_idx, 2'b00}) == '0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = load ? (hex_mode ? COMMIT : CONVERT) : IDLE;
            CONVERT: w_next = r_cnt == CW'(INPUT_WIDTH - 1) ? COMMIT : CONVERT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++)
            w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] >= 4'd5 ? r_bcd[4*d +: 4] + 4'd3 : r_bcd[4*d +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val  <= '0;
            r_sh   <= '0;
            r_hex  <= 1'b0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_val <= value;
            r_sh  <= value;
            r_hex <= hex_mode;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == CONVERT) begin
            r_bcd <= {w_bcd_adj[BW-2:0], r_sh[INPUT_WIDTH-1]};
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == COMMIT) begin
            r_disp <= r_hex ? w_ext[BW-1:0] : r_bcd;
            r_ovf  <= w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
            digit <= '1;
        end else begin
            r_ref <= w_wrap ? '0 : r_ref + 1'b1;
            if (w_wrap) r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
            seg   <= r_ovf ? 7'b1111110 : w_blank ? 7'b1111111 : GLYPH[w_nib];
            dp    <= ~dp_mask[r_idx];
            digit <= ~(NUM_DIGITS'(1) << r_idx);
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: randomized and directed checks against a digit-arithmetic model.
module tb_seg7_scan_display;
    logic        clk = 1'b0;
    logic        rst, load, hex_mode, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [0:6]  seg;
    logic        dp, busy;
    logic [3:0]  digit;
    logic        load20, hex20;
    logic [19:0] value20;
    logic [0:6]  seg20;
    logic        dp20, busy20;
    logic [3:0]  digit20;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    seg7_scan_display #(.NUM_DIGITS(4), .INPUT_WIDTH(16), .REFRESH_COUNT(4)) u_dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .seg(seg), .dp(dp), .digit(digit), .busy(busy)
    );

    seg7_scan_display #(.NUM_DIGITS(4), .INPUT_WIDTH(20), .REFRESH_COUNT(4)) u_dut20 (
        .clk(clk), .rst(rst), .value(value20), .load(load20), .hex_mode(hex20),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .seg(seg20), .dp(dp20), .digit(digit20), .busy(busy20)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] en_of(input int i);
        return ~(4'b0001 << i);
    endfunction

    // Expected glyph of digit i: positional arithmetic on the value itself
    function automatic logic [6:0] model_seg(input longint v, input bit hx, input bit blz, input int i);
        longint base = hx ? 64'd16 : 64'd10;
        longint p = 1;
        longint lim = base * base * base * base;
        for (int k = 0; k < i; k++) p *= base;
        if (v >= lim) return 7'b1111110;
        if (blz && i > 0 && v < p) return 7'b1111111;
        return glyph_tab[int'((v / p) % base)];
    endfunction

    task automatic do_load(input bit s, input longint v, input bit hx, input string tag);
        int n = 0;
        if (s) begin value20 = 20'(v); hex20 = hx; load20 = 1'b1; end
        else begin value = 16'(v); hex_mode = hx; load = 1'b1; end
        @(negedge clk);
        load = 1'b0;
        load20 = 1'b0;
        while ((s ? busy20 : busy) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("%s busy_len", tag), n, hx ? 1 : (s ? 21 : 17));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_disp(input bit s, input longint v, input bit hx, input string tag);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] en;
            logic       e_dp;
            int         k;
            en = en_of(i);
            e_dp = ~dp_mask[i];
            k = 0;
            while ((s ? digit20 : digit) !== en && k < 40) begin
                k++;
                @(negedge clk);
            end
            check($sformatf("%s en%0d", tag, i), s ? digit20 : digit, en);
            check($sformatf("%s seg%0d", tag, i), s ? seg20 : seg, model_seg(v, hx, blank_lz, i));
            check($sformatf("%s dp%0d", tag, i), s ? dp20 : dp, e_dp);
        end
    endtask

    initial begin
        int n;
        longint v;
        bit hx;
        rst = 1'b1; load = 1'b0; load20 = 1'b0; hex_mode = 1'b0; hex20 = 1'b0;
        value = '0; value20 = '0; blank_lz = 1'b0; dp_mask = '0;
        repeat (3) @(negedge clk);
        check("rst seg", seg, 7'b1111111);
        check("rst digit", digit, 4'b1111);
        check("rst dp", dp, 1'b1);
        check("rst busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("walk en%0d", j), digit, en_of(j % 4));
            check($sformatf("walk seg%0d", j), seg, 7'b0000001);
            if (j < 4) repeat (4) @(negedge clk);
        end

        do_load(0, 1234, 0, "dec1234");
        check_disp(0, 1234, 0, "dec1234");
        do_load(0, 16'hBEEF, 1, "hexBEEF");
        check_disp(0, 16'hBEEF, 1, "hexBEEF");
        do_load(0, 9999, 0, "dec9999");
        check_disp(0, 9999, 0, "dec9999");
        do_load(0, 10000, 0, "ovf10000");
        check_disp(0, 10000, 0, "ovf10000");
        do_load(1, 20'h10000, 1, "ovfhex20");
        check_disp(1, 20'h10000, 1, "ovfhex20");
        do_load(1, 20'h0FFFF, 1, "hex20max");
        check_disp(1, 20'h0FFFF, 1, "hex20max");
        do_load(1, 65535, 0, "dec20ovf");
        check_disp(1, 65535, 0, "dec20ovf");

        blank_lz = 1'b1;
        dp_mask = 4'b0010;
        do_load(0, 42, 0, "blank42");
        check_disp(0, 42, 0, "blank42");
        do_load(0, 0, 0, "blank0");
        check_disp(0, 0, 0, "blank0");
        do_load(0, 16'h00A0, 1, "blankhex");
        check_disp(0, 16'h00A0, 1, "blankhex");

        for (int r = 0; r < 12; r++) begin
            blank_lz = 1'($urandom_range(0, 1));
            dp_mask = 4'($urandom);
            hx = 1'($urandom_range(0, 1));
            v = hx ? longint'($urandom_range(0, 65535)) : longint'($urandom_range(0, 10500));
            do_load(0, v, hx, $sformatf("rnd%0d", r));
            check_disp(0, v, hx, $sformatf("rnd%0d", r));
        end

        blank_lz = 1'b0;
        dp_mask = 4'b0000;
        value = 16'd1234; hex_mode = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check("hs busy5", busy, 1'b1);
        value = 16'd9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 5;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("hs busy_len", n, 17);
        repeat (2) @(negedge clk);
        check_disp(0, 1234, 0, "hs ignore");

        value = 16'd5678; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        check("abort busy8", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_disp(0, 0, 0, "abort disp");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
